// File: rtl/dac_sched_pkg.sv
// Shared types and frame layout for the dual-channel DAC frame scheduler.
package dac_sched_pkg;

    localparam int FRAME_W    = 16;
    localparam int CH_SEL_BIT = 15;
    localparam int GA_N_BIT   = 13;
    localparam int SHDN_N_BIT = 12;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FRAME_A = 3'd1,
        GAP_A   = 3'd2,
        FRAME_B = 3'd3,
        GAP_B   = 3'd4,
        LDAC    = 3'd5
    } sched_state_t;

    // Bit 14 stays 0; GA_n is always 1 (1x gain).
    function automatic logic [FRAME_W-1:0] build_frame(input logic ch_b,
                                                       input logic shdn_n,
                                                       input logic [11:0] sample);
        logic [FRAME_W-1:0] w;
        w             = '0;
        w[11:0]       = sample;
        w[CH_SEL_BIT] = ch_b;
        w[GA_N_BIT]   = 1'b1;
        w[SHDN_N_BIT] = shdn_n;
        return w;
    endfunction

endpackage

// File: rtl/spi_tx16.sv
// 16-bit SPI mode-0 serialiser: cs_n/mosi set on the start edge, sclk
// rises CLK_DIV cycles later, mosi shifts on each sclk fall, cs_n rises
// together with the 16th fall. done is high in the cycle whose closing
// edge ends the frame, so the caller can change state on that same edge.
module spi_tx16
    import dac_sched_pkg::*;
#(
    parameter int CLK_DIV = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [FRAME_W-1:0] word,
    output logic               sclk,
    output logic               mosi,
    output logic               cs_n,
    output logic               done
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(CLK_DIV - 1);

    logic               active;
    logic [DIV_W-1:0]   div_cnt;
    logic [3:0]         bit_cnt;
    logic [FRAME_W-1:0] shreg;

    // mosi comes straight from the shift-register MSB flop; cleared between frames.
    assign mosi = shreg[FRAME_W-1];
    assign done = active && sclk && (div_cnt == '0) && (bit_cnt == 4'd15);

    // Half-period down-counter, bit counter and shifter; all idle at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active  <= 1'b0;
            div_cnt <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
            sclk    <= 1'b0;
            cs_n    <= 1'b1;
        end else if (start && !active) begin
            active  <= 1'b1;
            div_cnt <= DIV_LOAD;
            bit_cnt <= '0;
            shreg   <= word;
            sclk    <= 1'b0;
            cs_n    <= 1'b0;
        end else if (active) begin
            if (div_cnt != '0) begin
                div_cnt <= div_cnt - 1'b1;
            end else if (!sclk) begin
                sclk    <= 1'b1;
                div_cnt <= DIV_LOAD;
            end else begin
                sclk <= 1'b0;
                if (bit_cnt == 4'd15) begin
                    active  <= 1'b0;
                    cs_n    <= 1'b1;
                    shreg   <= '0;
                    bit_cnt <= '0;
                end else begin
                    bit_cnt <= bit_cnt + 4'd1;
                    shreg   <= {shreg[FRAME_W-2:0], 1'b0};
                    div_cnt <= DIV_LOAD;
                end
            end
        end
    end

endmodule

// File: rtl/dac_frame_scheduler.sv
// Dual-channel DAC frame scheduler: per sample_tick sends frame A then
// frame B over one SPI link, then (optionally) a shared LDAC strobe.
// Build option: define LDAC_SYNC_EN for the simultaneous-update LDAC
// pulse; without it ldac_n is tied low and each channel updates at its
// own cs_n rise.
//
// state   | meaning
// --------+------------------------------------------------
// IDLE    | waiting for sample_tick
// FRAME_A | channel A frame on the wire
// GAP_A   | cs_n high between frames, CS_GAP cycles
// FRAME_B | channel B frame on the wire
// GAP_B   | cs_n high after frame B, CS_GAP cycles
// LDAC    | ldac_n low LDAC_CYCLES cycles (LDAC_SYNC_EN only)
module dac_frame_scheduler
    import dac_sched_pkg::*;
#(
    parameter int CLK_DIV     = 2,
    parameter int CS_GAP      = 2,
    parameter int LDAC_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sample_tick,
    input  logic [11:0] a_corr,
    input  logic [11:0] b_corr,
    input  logic [1:0]  chan_en,
    input  logic        overrun_clr,
    output logic        sclk,
    output logic        mosi,
    output logic        cs_n,
    output logic        ldac_n,
    output logic        busy,
    output logic        overrun
);

    localparam int TMR_MAX = (CS_GAP > LDAC_CYCLES) ? CS_GAP : LDAC_CYCLES;
    localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;
    localparam logic [TMR_W-1:0] GAP_LOAD = TMR_W'(CS_GAP - 1);
`ifdef LDAC_SYNC_EN
    localparam logic [TMR_W-1:0] LDAC_LOAD = TMR_W'(LDAC_CYCLES - 1);
`endif

    sched_state_t       state, state_nxt;
    logic [TMR_W-1:0]   tmr, tmr_nxt;
    logic [11:0]        lat_b;
    logic               lat_shdn_b;
    logic               spi_start;
    logic               spi_done;
    logic [FRAME_W-1:0] spi_word;

    // The A word is captured by the serialiser on the accepting edge, so
    // only the B half needs holding here.
    assign spi_word = (state == IDLE) ? build_frame(1'b0, chan_en[0], a_corr)
                                      : build_frame(1'b1, lat_shdn_b, lat_b);

    spi_tx16 #(.CLK_DIV(CLK_DIV)) u_spi (
        .clk   (clk),
        .rst_n (rst_n),
        .start (spi_start),
        .word  (spi_word),
        .sclk  (sclk),
        .mosi  (mosi),
        .cs_n  (cs_n),
        .done  (spi_done)
    );

    // Next-state, gap/LDAC timer and serialiser start decode.
    always_comb begin
        state_nxt = state;
        tmr_nxt   = tmr;
        spi_start = 1'b0;
        case (state)
            IDLE: if (sample_tick) begin
                state_nxt = FRAME_A;
                spi_start = 1'b1;
            end
            FRAME_A: if (spi_done) begin
                state_nxt = GAP_A;
                tmr_nxt   = GAP_LOAD;
            end
            GAP_A: if (tmr == '0) begin
                state_nxt = FRAME_B;
                spi_start = 1'b1;
            end else begin
                tmr_nxt = tmr - 1'b1;
            end
            FRAME_B: if (spi_done) begin
                state_nxt = GAP_B;
                tmr_nxt   = GAP_LOAD;
            end
            GAP_B: if (tmr == '0) begin
`ifdef LDAC_SYNC_EN
                state_nxt = LDAC;
                tmr_nxt   = LDAC_LOAD;
`else
                state_nxt = IDLE;
`endif
            end else begin
                tmr_nxt = tmr - 1'b1;
            end
`ifdef LDAC_SYNC_EN
            LDAC: if (tmr == '0) begin
                state_nxt = IDLE;
            end else begin
                tmr_nxt = tmr - 1'b1;
            end
`endif
            default: state_nxt = IDLE;
        endcase
    end

    // State, timer, busy flag and the channel B sample hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            tmr        <= '0;
            busy       <= 1'b0;
            lat_b      <= '0;
            lat_shdn_b <= 1'b0;
        end else begin
            state <= state_nxt;
            tmr   <= tmr_nxt;
            busy  <= (state_nxt != IDLE);
            if (state == IDLE && sample_tick) begin
                lat_b      <= b_corr;
                lat_shdn_b <= chan_en[1];
            end
        end
    end

    // Sticky overrun: a tick while busy sets it and beats a same-cycle clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun <= 1'b0;
        end else if (sample_tick && state != IDLE) begin
            overrun <= 1'b1;
        end else if (overrun_clr) begin
            overrun <= 1'b0;
        end
    end

`ifdef LDAC_SYNC_EN
    // Registered strobe so ldac_n is a clean flop output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ldac_n <= 1'b1;
        end else begin
            ldac_n <= (state_nxt != LDAC);
        end
    end
`else
    assign ldac_n = 1'b0;
`endif

endmodule

// File: tb/tb_dac_frame_scheduler.sv
// Self-checking bench for dac_frame_scheduler (adapts to LDAC_SYNC_EN).
module tb_dac_frame_scheduler;

    localparam int CD  = 2;
    localparam int GAP = 2;
    localparam int LDC = 2;
`ifdef LDAC_SYNC_EN
    localparam int   BUSY_EXP       = 64*CD + 2*GAP + LDC;
    localparam int   LDAC_LOW_EXP   = LDC;
    localparam int   LDAC_FIRST_EXP = 64*CD + 2*GAP;
    localparam logic LDAC_IDLE      = 1'b1;
`else
    localparam int   BUSY_EXP       = 64*CD + 2*GAP;
    localparam int   LDAC_LOW_EXP   = 64*CD + 2*GAP;
    localparam int   LDAC_FIRST_EXP = 0;
    localparam logic LDAC_IDLE      = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sample_tick;
    logic [11:0] a_corr, b_corr;
    logic [1:0]  chan_en;
    logic        overrun_clr;
    logic        sclk, mosi, cs_n, ldac_n, busy, overrun;

    int n_checks = 0;
    int n_pass   = 0;

    logic [15:0] exp_q[$];
    logic [15:0] cap_word;
    logic [15:0] mon_exp;
    int          cap_bits;
    int          low_cycles;

    dac_frame_scheduler #(.CLK_DIV(CD), .CS_GAP(GAP), .LDAC_CYCLES(LDC)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .sample_tick (sample_tick),
        .a_corr      (a_corr),
        .b_corr      (b_corr),
        .chan_en     (chan_en),
        .overrun_clr (overrun_clr),
        .sclk        (sclk),
        .mosi        (mosi),
        .cs_n        (cs_n),
        .ldac_n      (ldac_n),
        .busy        (busy),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] frm(input logic ch, input logic en, input logic [11:0] s);
        return {ch, 1'b0, 1'b1, en, s};
    endfunction

    // Frame capture: bits sampled on sclk rises while cs_n is low.
    always @(negedge cs_n) begin
        cap_bits   = 0;
        cap_word   = '0;
        low_cycles = 0;
    end

    always @(posedge sclk) if (cs_n === 1'b0) begin
        cap_word = {cap_word[14:0], mosi};
        cap_bits++;
    end

    always @(posedge clk) if (cs_n === 1'b0) low_cycles++;

    // Scoreboard: each completed frame pops the oldest expected word.
    always @(posedge cs_n) if (rst_n === 1'b1) begin
        n_checks++;
        if (exp_q.size() == 0) begin
            $display("FAIL unexpected_frame got=%h bits=%0d", cap_word, cap_bits);
        end else begin
            mon_exp = exp_q.pop_front();
            if (cap_word !== mon_exp || cap_bits != 16)
                $display("FAIL frame_word got=%h bits=%0d expected=%h bits=16", cap_word, cap_bits, mon_exp);
            else
                n_pass++;
            n_checks++;
            if (low_cycles != 32*CD)
                $display("FAIL cs_low_cycles got=%0d expected=%0d", low_cycles, 32*CD);
            else
                n_pass++;
        end
    end

    // Pulse a tick at the current negedge and measure the busy window.
    task automatic run_seq(input logic [11:0] a, input logic [11:0] b, input logic [1:0] en,
                           output int busy_cyc, output int ldac_low, output int first_ldac);
        a_corr = a; b_corr = b; chan_en = en; sample_tick = 1'b1;
        exp_q.push_back(frm(1'b0, en[0], a));
        exp_q.push_back(frm(1'b1, en[1], b));
        @(negedge clk);
        sample_tick = 1'b0;
        busy_cyc = 0; ldac_low = 0; first_ldac = -1;
        while (busy === 1'b1 && busy_cyc < 1000) begin
            if (ldac_n === 1'b0) begin
                if (first_ldac < 0) first_ldac = busy_cyc;
                ldac_low++;
            end
            busy_cyc++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; sample_tick = 1'b0; overrun_clr = 1'b0;
        a_corr = '0; b_corr = '0; chan_en = 2'b00;
        repeat (3) @(negedge clk);
        n_checks++; if (cs_n !== 1'b1) $display("FAIL reset_cs_n got=%b expected=1", cs_n); else n_pass++;
        n_checks++; if (sclk !== 1'b0) $display("FAIL reset_sclk got=%b expected=0", sclk); else n_pass++;
        n_checks++; if (mosi !== 1'b0) $display("FAIL reset_mosi got=%b expected=0", mosi); else n_pass++;
        n_checks++; if (ldac_n !== LDAC_IDLE) $display("FAIL reset_ldac_n got=%b expected=%b", ldac_n, LDAC_IDLE); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b expected=0", busy); else n_pass++;
        n_checks++; if (overrun !== 1'b0) $display("FAIL reset_overrun got=%b expected=0", overrun); else n_pass++;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_basic();
        int bc, ll, fl;
        run_seq(12'h800, 12'h3FF, 2'b11, bc, ll, fl);
        n_checks++; if (bc != BUSY_EXP) $display("FAIL basic_busy got=%0d expected=%0d", bc, BUSY_EXP); else n_pass++;
        n_checks++; if (ll != LDAC_LOW_EXP) $display("FAIL basic_ldac_low got=%0d expected=%0d", ll, LDAC_LOW_EXP); else n_pass++;
        n_checks++; if (fl != LDAC_FIRST_EXP) $display("FAIL basic_ldac_start got=%0d expected=%0d", fl, LDAC_FIRST_EXP); else n_pass++;
        n_checks++; if (ldac_n !== LDAC_IDLE) $display("FAIL basic_ldac_after got=%b expected=%b", ldac_n, LDAC_IDLE); else n_pass++;
        n_checks++; if (overrun !== 1'b0) $display("FAIL basic_overrun got=%b expected=0", overrun); else n_pass++;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_shutdown();
        int bc, ll, fl;
        run_seq(12'h123, 12'h456, 2'b10, bc, ll, fl);
        n_checks++; if (bc != BUSY_EXP) $display("FAIL shdn_a_busy got=%0d expected=%0d", bc, BUSY_EXP); else n_pass++;
        repeat (2) @(negedge clk);
        run_seq(12'hC3C, 12'h0FF, 2'b01, bc, ll, fl);
        n_checks++; if (bc != BUSY_EXP) $display("FAIL shdn_b_busy got=%0d expected=%0d", bc, BUSY_EXP); else n_pass++;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_overrun();
        int n;
        a_corr = 12'h555; b_corr = 12'hAAA; chan_en = 2'b11; sample_tick = 1'b1;
        exp_q.push_back(frm(1'b0, 1'b1, 12'h555));
        exp_q.push_back(frm(1'b1, 1'b1, 12'hAAA));
        @(negedge clk);
        sample_tick = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 1000) begin
            if (n == 50) begin
                n_checks++; if (overrun !== 1'b0) $display("FAIL ovr_before got=%b expected=0", overrun); else n_pass++;
                sample_tick = 1'b1; a_corr = 12'hFFF; b_corr = 12'h000;
            end else if (n == 51) begin
                sample_tick = 1'b0;
                n_checks++; if (overrun !== 1'b1) $display("FAIL ovr_set got=%b expected=1", overrun); else n_pass++;
            end else if (n == 60) begin
                sample_tick = 1'b1; overrun_clr = 1'b1;
            end else if (n == 61) begin
                sample_tick = 1'b0; overrun_clr = 1'b0;
                n_checks++; if (overrun !== 1'b1) $display("FAIL ovr_set_wins got=%b expected=1", overrun); else n_pass++;
            end
            n++;
            @(negedge clk);
        end
        n_checks++; if (n != BUSY_EXP) $display("FAIL ovr_busy got=%0d expected=%0d", n, BUSY_EXP); else n_pass++;
        @(negedge clk);
        n_checks++; if (overrun !== 1'b1) $display("FAIL ovr_sticky got=%b expected=1", overrun); else n_pass++;
        overrun_clr = 1'b1;
        @(negedge clk);
        overrun_clr = 1'b0;
        n_checks++; if (overrun !== 1'b0) $display("FAIL ovr_clear got=%b expected=0", overrun); else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_isolation();
        int n;
        a_corr = 12'hABC; b_corr = 12'hDEF; chan_en = 2'b11; sample_tick = 1'b1;
        exp_q.push_back(frm(1'b0, 1'b1, 12'hABC));
        exp_q.push_back(frm(1'b1, 1'b1, 12'hDEF));
        @(negedge clk);
        sample_tick = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 1000) begin
            if (n == 10) begin
                a_corr = 12'h111; b_corr = 12'h222; chan_en = 2'b00;
            end
            n++;
            @(negedge clk);
        end
        n_checks++; if (n != BUSY_EXP) $display("FAIL iso_busy got=%0d expected=%0d", n, BUSY_EXP); else n_pass++;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int bc, ll, fl;
        a_corr = 12'h4D2; b_corr = 12'h9E7; chan_en = 2'b11; sample_tick = 1'b1;
        exp_q.push_back(frm(1'b0, 1'b1, 12'h4D2));
        exp_q.push_back(frm(1'b1, 1'b1, 12'h9E7));
        @(negedge clk);
        sample_tick = 1'b0;
        repeat (32*CD + GAP + 20) @(negedge clk);
        @(posedge clk);
        #2;
        n_checks++; if (cs_n !== 1'b0) $display("FAIL mid_in_frame_b cs_n got=%b expected=0", cs_n); else n_pass++;
        rst_n = 1'b0;
        #1;
        n_checks++; if (cs_n !== 1'b1) $display("FAIL mid_rst_cs_n got=%b expected=1", cs_n); else n_pass++;
        n_checks++; if (sclk !== 1'b0) $display("FAIL mid_rst_sclk got=%b expected=0", sclk); else n_pass++;
        n_checks++; if (ldac_n !== LDAC_IDLE) $display("FAIL mid_rst_ldac_n got=%b expected=%b", ldac_n, LDAC_IDLE); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL mid_rst_busy got=%b expected=0", busy); else n_pass++;
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_seq(12'h7E5, 12'h1A2, 2'b11, bc, ll, fl);
        n_checks++; if (bc != BUSY_EXP) $display("FAIL mid_after_busy got=%0d expected=%0d", bc, BUSY_EXP); else n_pass++;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int bc, ll, fl;
        run_seq(12'h0F0, 12'hF0F, 2'b11, bc, ll, fl);
        n_checks++; if (bc != BUSY_EXP) $display("FAIL b2b_first_busy got=%0d expected=%0d", bc, BUSY_EXP); else n_pass++;
        run_seq(12'h321, 12'hCDE, 2'b11, bc, ll, fl);
        n_checks++; if (bc != BUSY_EXP) $display("FAIL b2b_second_busy got=%0d expected=%0d", bc, BUSY_EXP); else n_pass++;
        n_checks++; if (ll != LDAC_LOW_EXP) $display("FAIL b2b_ldac_low got=%0d expected=%0d", ll, LDAC_LOW_EXP); else n_pass++;
        n_checks++; if (overrun !== 1'b0) $display("FAIL b2b_overrun got=%b expected=0", overrun); else n_pass++;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_shutdown();
        test_overrun();
        test_isolation();
        test_reset_mid();
        test_back_to_back();
        repeat (5) @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0) $display("FAIL frames_missing got=%0d pending expected=0", exp_q.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog_timeout got=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
